// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory/IO port between the CPU MEM stage and a debug/loader port
module dmem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_write,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic [15:0] dbg_rdata,
  output logic        dbg_valid,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [15:0] mem_rdata
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [15:0]       dbg_rdata_q, dbg_rdata_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic              dbg_win, cpu_gnt, starved;

  assign dbg_rdata = dbg_rdata_q;
  assign dbg_valid = dbg_valid_q;

  // Grant decision and memory port mux; every strobe is forced low while reset_n is low
  always_comb begin
    starved   = starve_cnt_q == CNT_W'(STARVE_MAX);
    dbg_win   = (state_q == LOCK) ? dbg_req : dbg_req & (~cpu_req | starved);
    dbg_gnt   = reset_n & dbg_win;
    cpu_gnt   = reset_n & (state_q == IDLE) & cpu_req & ~dbg_win;
    cpu_stall = reset_n & cpu_req & ~cpu_gnt;
    mem_addr  = cpu_gnt ? cpu_addr : dbg_gnt ? dbg_addr : '0;
    mem_wdata = cpu_gnt ? cpu_wdata : dbg_gnt ? dbg_wdata : '0;
    mem_write = cpu_gnt ? cpu_write : dbg_gnt & dbg_write;
    mem_read  = cpu_gnt ? ~cpu_write : dbg_gnt & ~dbg_write;
    cpu_rdata = cpu_gnt ? mem_rdata : '0;
  end

  // Next state: lock entry on a locked debug grant, exit when dbg_lock is sampled low
  always_comb begin
    state_d      = (state_q == IDLE) ? ((dbg_gnt & dbg_lock) ? LOCK : IDLE) : (dbg_lock ? LOCK : IDLE);
    starve_cnt_d = (dbg_req & ~dbg_gnt) ? (starved ? starve_cnt_q : starve_cnt_q + 1'b1) : '0;
    dbg_valid_d  = dbg_gnt & ~dbg_write;
    dbg_rdata_d  = dbg_valid_d ? mem_rdata : dbg_rdata_q;
  end

  // State, starvation counter and registered debug read data
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      dbg_rdata_q  <= '0;
      dbg_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_valid_q  <= dbg_valid_d;
    end
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/IO port (DMemory_IO) between the pipeline MEM stage (CPU) and a debug/loader port.
- CPU has fixed priority. Bounded starvation protection guarantees debug progress.
- Debug may lock the port for multi-word bursts.
- Sits between the EX/MEM register outputs and DMemory_IO. Drives the pipeline stall when the CPU is denied.

Parameters:
STARVE_MAX, 4, consecutive denied debug-request cycles after which debug wins over CPU (1..7)
CNT_W, 3, width of starvation counter; must hold STARVE_MAX

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
cpu_req  input  1  MEM stage requests memory (memread | memwrite)
cpu_write  input  1  1 = write, 0 = read
cpu_addr  input  16  CPU byte address
cpu_wdata  input  16  CPU write data
cpu_rdata  output  16  read data to MEM/WB, combinational
cpu_stall  output  1  cpu_req & ~cpu_gnt; freezes PC/IFID/IDEX/EXMEM
dbg_req  input  1  debug port request
dbg_write  input  1  1 = write, 0 = read
dbg_addr  input  16  debug byte address
dbg_wdata  input  16  debug write data
dbg_lock  input  1  hold grant across consecutive debug accesses
dbg_gnt  output  1  debug access performed this cycle, combinational
dbg_rdata  output  16  registered debug read data
dbg_valid  output  1  one-cycle pulse, dbg_rdata valid
mem_addr  output  16  to DMemory_IO addr
mem_wdata  output  16  to DMemory_IO wdata
mem_write  output  1  to DMemory_IO write
mem_read  output  1  to DMemory_IO read
mem_rdata  input  16  from DMemory_IO rdata

Behaviour:

State and reset:
- States: IDLE, LOCK.
- Reset (reset_n low, asynchronous):
  - state=IDLE, starve_cnt=0, dbg_rdata=0, dbg_valid=0.
  - While reset_n is low: mem_write=0, mem_read=0, cpu_stall=0, dbg_gnt=0. These outputs are gated combinationally by reset_n.
- Reset asserted during LOCK aborts the lock. No write completes on an edge where reset_n is low.

Grant, evaluated combinationally each cycle; at most one of cpu_gnt/dbg_gnt is high:
- LOCK and dbg_req=1: debug granted, CPU denied.
- LOCK and dbg_req=0: nobody granted. CPU is stalled if it requests (lock hold-off).
- IDLE, only one requester: that requester is granted.
- IDLE, both requesting: CPU granted unless starve_cnt == STARVE_MAX, in which case debug is granted.
- IDLE, no requests: no grant.

Transitions, at the rising edge:
- IDLE -> LOCK: dbg_gnt & dbg_lock.
- LOCK -> IDLE: dbg_lock=0. This takes effect at the edge where dbg_lock is sampled low; the grant in that same cycle still follows the LOCK rules.

Starvation counter (starve_cnt):
- Increments each edge with dbg_req & ~dbg_gnt, saturating at STARVE_MAX.
- Clears when dbg_gnt=1 or dbg_req=0.

Memory port mux:
- Granted requester's addr/wdata drive mem_addr/mem_wdata.
- mem_write = gnt & write; mem_read = gnt & ~write.
- No grant: mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0.

Read data:
- cpu_rdata = mem_rdata when the CPU is granted, else 0. Zero latency; the pipeline samples it at the same edge.
- Debug read granted: dbg_rdata <= mem_rdata and dbg_valid <= 1 at that edge, so valid appears one cycle after the grant. Otherwise dbg_valid <= 0 and dbg_rdata holds.
- Debug writes never pulse dbg_valid.

Misc:
- Requesters must hold req/addr/wdata/write stable until granted.
- No address filtering: IO addresses 0xfff0/0xfffa pass through unchanged.
- cpu_stall must not depend on cpu_rdata, to avoid a combinational loop.

Test Plan:
1. Reset: reset_n low mid-cycle while cpu_req=1, cpu_write=1 -> mem_write=0 immediately; after release, state=IDLE, dbg_valid=0, dbg_rdata=0.
2. CPU-only write then read: cpu write addr 0x0010, data 0xBEEF -> mem_write=1, cpu_stall=0. Next cycle cpu read 0x0010 -> cpu_rdata=0xBEEF in the same cycle.
3. Debug read: dbg_req=1, read 0x0010 with cpu_req=0 -> dbg_gnt=1 that cycle; dbg_valid=1 and dbg_rdata=0xBEEF the next cycle, for exactly one cycle.
4. Contention, STARVE_MAX=4: cpu_req and dbg_req both held high -> CPU granted 4 consecutive cycles, then debug granted on cycle 5 with cpu_stall=1. The pattern repeats with period 5.
5. Lock burst: debug writes 0x0020/0x0022/0x0024 with dbg_lock=1 while cpu_req=1 -> cpu_stall=1 for all 3 cycles. dbg_lock drops with the last access -> CPU granted the following cycle.
6. IO passthrough: CPU write to 0xfffa with wdata=0x005B -> mem_addr=0xfffa, mem_write=1, and the display register loads 0x5B. Debug read of 0xfff0 with switches SW1=1, SW0=0 -> dbg_rdata=0x0002.
